// File: rtl/reglk_write_filter.sv
// reglk_write_filter: gates config-bus requests against the register-lock vector.
// Every accepted request passes through one CHECK cycle, where the lock bit for
// its index is sampled. Locked or out-of-range writes are refused with an error
// response and logged. Allowed requests are forwarded downstream and acknowledged
// once the register file takes them.
// Optional build macro: REGLK_READ_CHECK_EN. When it is defined, reads are
// lock-checked the same way as writes.
module reglk_write_filter #(
    parameter int NUM_LK_WORDS = 6,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int CNT_W        = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [32*NUM_LK_WORDS-1:0] reglk_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_we_i,
    input  logic [ADDR_W-1:0]          req_addr_i,
    input  logic [DATA_W-1:0]          req_wdata_i,
    output logic                       dn_valid_o,
    input  logic                       dn_ready_i,
    output logic                       dn_we_o,
    output logic [ADDR_W-1:0]          dn_addr_o,
    output logic [DATA_W-1:0]          dn_wdata_o,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic                       rsp_err_o,
    input  logic                       viol_clr_i,
    output logic [CNT_W-1:0]           viol_cnt_o,
    output logic                       viol_sticky_o,
    output logic [ADDR_W-1:0]          viol_addr_o
);

    localparam int LK_BITS = 32 * NUM_LK_WORDS;
    localparam int NUM_IDX = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FWD   = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;
    logic                viol_sticky_q, viol_sticky_d;
    logic [ADDR_W-1:0]   viol_addr_q, viol_addr_d;

    logic [NUM_IDX-1:0]  lk_ext;
    logic                check_en;
    logic                deny;
    logic [CNT_W-1:0]    cnt_base;
    logic                sticky_base;

    // Extend the lock vector over the whole index space. Indices with no lock
    // bit behind them read as locked, so out-of-range is just another lock bit.
    generate
        for (genvar gi = 0; gi < NUM_IDX; gi++) begin : g_lk
            if (gi < LK_BITS) begin : g_in
                assign lk_ext[gi] = reglk_i[gi];
            end else begin : g_oor
                assign lk_ext[gi] = 1'b1;
            end
        end
    endgenerate

`ifdef REGLK_READ_CHECK_EN
    assign check_en = 1'b1;
`else
    assign check_en = we_q;
`endif

    // The lock decision is taken from the captured index, only in CHECK.
    assign deny = (state_q == CHECK) && check_en && lk_ext[addr_q];

    // The clear is applied before a same-cycle denial is counted.
    assign cnt_base    = viol_clr_i ? '0 : viol_cnt_q;
    assign sticky_base = viol_clr_i ? 1'b0 : viol_sticky_q;

    // Next-state, request capture and violation logging.
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        viol_cnt_d    = cnt_base;
        viol_sticky_d = sticky_base;
        viol_addr_d   = viol_addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                err_d = deny;
                if (deny) begin
                    state_d       = RESP;
                    viol_sticky_d = 1'b1;
                    viol_addr_d   = addr_q;
                    if (cnt_base != {CNT_W{1'b1}}) begin
                        viol_cnt_d = cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = FWD;
                end
            end
            FWD: begin
                if (dn_ready_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            err_q         <= 1'b0;
            viol_cnt_q    <= '0;
            viol_sticky_q <= 1'b0;
            viol_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            viol_cnt_q    <= viol_cnt_d;
            viol_sticky_q <= viol_sticky_d;
            viol_addr_q   <= viol_addr_d;
        end
    end

    assign req_ready_o   = (state_q == IDLE);
    assign dn_valid_o    = (state_q == FWD);
    assign dn_we_o       = dn_valid_o & we_q;
    assign dn_addr_o     = dn_valid_o ? addr_q : '0;
    assign dn_wdata_o    = dn_valid_o ? wdata_q : '0;
    assign rsp_valid_o   = (state_q == RESP);
    assign rsp_err_o     = rsp_valid_o & err_q;
    assign viol_cnt_o    = viol_cnt_q;
    assign viol_sticky_o = viol_sticky_q;
    assign viol_addr_o   = viol_addr_q;

endmodule

// File: tb/tb_reglk_write_filter.sv
// Bench for reglk_write_filter: a vector table, hand-written corner sequences
// and randomized transactions, all checked against a rule-level model.
module tb_reglk_write_filter;

    localparam int LKB   = 192;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;
`ifdef REGLK_READ_CHECK_EN
    localparam bit RD_CHK = 1'b1;
`else
    localparam bit RD_CHK = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [LKB-1:0]    reglk_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [7:0]        req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              dn_valid_o;
    logic              dn_ready_i;
    logic              dn_we_o;
    logic [7:0]        dn_addr_o;
    logic [31:0]       dn_wdata_o;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_err_o;
    logic              viol_clr_i;
    logic [CNT_W-1:0]  viol_cnt_o;
    logic              viol_sticky_o;
    logic [7:0]        viol_addr_o;

    int n_tests = 0;
    int n_fail  = 0;

    int m_cnt    = 0;
    bit m_sticky = 0;
    int m_addr   = 0;

    always #5 clk_i = ~clk_i;

    reglk_write_filter #(
        .NUM_LK_WORDS(6), .ADDR_W(8), .DATA_W(32), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .reglk_i(reglk_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i), .dn_we_o(dn_we_o),
        .dn_addr_o(dn_addr_o), .dn_wdata_o(dn_wdata_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_err_o(rsp_err_o),
        .viol_clr_i(viol_clr_i), .viol_cnt_o(viol_cnt_o),
        .viol_sticky_o(viol_sticky_o), .viol_addr_o(viol_addr_o)
    );

    typedef struct {
        bit          we;
        int          addr;
        logic [31:0] wd;
        int          lmode;   // 0 all unlocked, 1 all locked, 2 all locked but target
        bit          exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Denial rule from the lock semantics: out of range is locked.
    function automatic bit ref_deny(input bit we, input int addr, input logic [LKB-1:0] lk);
        if (!(we || RD_CHK)) return 1'b0;
        if (addr >= LKB) return 1'b1;
        return lk[addr];
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Full transaction from acceptance to response handshake, checking every phase.
    task automatic run_txn(input bit we, input int addr, input logic [31:0] wd,
                           input int dn_wait, input int rsp_wait, input bit clr,
                           input bit flip, input bit exp_err, input string tag);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr[7:0];
        req_wdata_i = wd;
        chk({tag, ":idle_ready"}, {31'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        req_addr_i  = 8'($urandom);
        req_wdata_i = $urandom;
        req_we_i    = ~we;
        chk({tag, ":check_ready"}, {31'd0, req_ready_o}, 32'd0);
        chk({tag, ":check_dn"}, {31'd0, dn_valid_o}, 32'd0);
        chk({tag, ":check_rsp"}, {31'd0, rsp_valid_o}, 32'd0);
        viol_clr_i = clr;
        tick();
        viol_clr_i = 1'b0;
        if (clr) begin
            m_cnt    = 0;
            m_sticky = 1'b0;
        end
        if (exp_err) begin
            m_cnt    = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
            m_sticky = 1'b1;
            m_addr   = addr;
            chk({tag, ":deny_no_dn"}, {31'd0, dn_valid_o}, 32'd0);
        end else begin
            for (int i = 0; i < dn_wait; i++) begin
                chk({tag, ":wait_dn_valid"}, {31'd0, dn_valid_o}, 32'd1);
                chk({tag, ":wait_dn_addr"}, {24'd0, dn_addr_o}, addr);
                chk({tag, ":wait_dn_wdata"}, dn_wdata_o, wd);
                chk({tag, ":wait_ready"}, {31'd0, req_ready_o}, 32'd0);
                if (flip) reglk_i = '1;
                tick();
            end
            chk({tag, ":dn_valid"}, {31'd0, dn_valid_o}, 32'd1);
            chk({tag, ":dn_we"}, {31'd0, dn_we_o}, {31'd0, we});
            chk({tag, ":dn_addr"}, {24'd0, dn_addr_o}, addr);
            chk({tag, ":dn_wdata"}, dn_wdata_o, wd);
            dn_ready_i = 1'b1;
            tick();
            dn_ready_i = 1'b0;
        end
        for (int i = 0; i < rsp_wait; i++) begin
            chk({tag, ":hold_rsp"}, {30'd0, rsp_valid_o, rsp_err_o}, {30'd0, 1'b1, exp_err});
            chk({tag, ":hold_ready"}, {31'd0, req_ready_o}, 32'd0);
            chk({tag, ":hold_dn"}, {31'd0, dn_valid_o}, 32'd0);
            tick();
        end
        chk({tag, ":rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        chk({tag, ":rsp_err"}, {31'd0, rsp_err_o}, {31'd0, exp_err});
        chk({tag, ":viol_cnt"}, {28'd0, viol_cnt_o}, m_cnt);
        chk({tag, ":viol_sticky"}, {31'd0, viol_sticky_o}, {31'd0, m_sticky});
        chk({tag, ":viol_addr"}, {24'd0, viol_addr_o}, m_addr);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk({tag, ":done_rsp"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, ":done_ready"}, {31'd0, req_ready_o}, 32'd1);
        $display("[TB] %s we=%0d idx=%0d err=%0d cnt=%0d fails=%0d",
                 tag, we, addr, exp_err, viol_cnt_o, n_fail);
    endtask

    initial begin
        vecs[0] = '{1'b1,   5, 32'hA5A5A5A5, 1, 1'b1};
        vecs[1] = '{1'b1,  37, 32'h12345678, 2, 1'b0};
        vecs[2] = '{1'b1, 200, 32'h0BADF00D, 0, 1'b1};
        vecs[3] = '{1'b0,   3, 32'h00000000, 1, RD_CHK};
        vecs[4] = '{1'b1, 191, 32'hCAFEBABE, 2, 1'b0};
        vecs[5] = '{1'b1, 192, 32'h11111111, 0, 1'b1};
        vecs[6] = '{1'b1,   0, 32'h22222222, 1, 1'b1};
        vecs[7] = '{1'b0, 250, 32'h00000000, 0, RD_CHK};
        vecs[8] = '{1'b1,  64, 32'hDEAD0040, 0, 1'b0};

        rst_i = 1'b1;
        reglk_i = '1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        dn_ready_i = 1'b0; rsp_ready_i = 1'b0; viol_clr_i = 1'b0;
        tick();
        tick();
        chk("rst:req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst:outs", {28'd0, dn_valid_o, rsp_valid_o, rsp_err_o, viol_sticky_o}, 32'd0);
        chk("rst:cnt", {28'd0, viol_cnt_o}, 32'd0);
        rst_i = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            case (vecs[v].lmode)
                0: reglk_i = '0;
                1: reglk_i = '1;
                default: begin
                    reglk_i = '1;
                    if (vecs[v].addr < LKB) reglk_i[vecs[v].addr] = 1'b0;
                end
            endcase
            run_txn(vecs[v].we, vecs[v].addr, vecs[v].wd, 0, 0, 1'b0, 1'b0,
                    vecs[v].exp_err, $sformatf("vec%0d", v));
        end

        // Backpressure, with the target re-locked while waiting downstream.
        reglk_i = '1;
        reglk_i[37] = 1'b0;
        run_txn(1'b1, 37, 32'h5EED5EED, 4, 3, 1'b0, 1'b1, 1'b0, "bp");

        // Saturation after 17 denials, then a clear coinciding with the 18th.
        reglk_i = '1;
        for (int k = 0; k < 17; k++)
            run_txn(1'b1, k, 32'h0, 0, 0, 1'b0, 1'b0, 1'b1, $sformatf("sat%0d", k));
        chk("sat:cnt15", {28'd0, viol_cnt_o}, 32'd15);
        run_txn(1'b1, 20, 32'h0, 0, 0, 1'b1, 1'b0, 1'b1, "sat_clr");
        chk("sat:clr_cnt1", {28'd0, viol_cnt_o}, 32'd1);
        chk("sat:clr_sticky", {31'd0, viol_sticky_o}, 32'd1);

        // Clear alone leaves the last denied index in place.
        reglk_i = '0;
        run_txn(1'b1, 9, 32'h9, 0, 0, 1'b1, 1'b0, 1'b0, "clr_only");
        chk("clr_only:addr_kept", {24'd0, viol_addr_o}, 32'd20);

        // Reset while forwarding.
        reglk_i = '0;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 8'd10; req_wdata_i = 32'h10;
        tick();
        req_valid_i = 1'b0;
        tick();
        chk("rstmid:in_fwd", {31'd0, dn_valid_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rstmid:dn_drop", {31'd0, dn_valid_o}, 32'd0);
        chk("rstmid:ready", {31'd0, req_ready_o}, 32'd1);
        chk("rstmid:viol", {19'd0, viol_cnt_o, viol_sticky_o, viol_addr_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        m_cnt = 0; m_sticky = 1'b0; m_addr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid:no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end
        reglk_i = '1;
        run_txn(1'b0, 3, 32'h0, 0, 0, 1'b0, 1'b0, RD_CHK, "rstmid_read3");

        // Randomized traffic against the rule model.
        for (int r = 0; r < 40; r++) begin
            bit          we;
            int          addr;
            logic [31:0] wd;
            bit          e;
            for (int w = 0; w < 6; w++) reglk_i[32*w +: 32] = $urandom;
            we   = 1'($urandom_range(0, 1));
            addr = $urandom_range(0, 255);
            wd   = $urandom;
            e    = ref_deny(we, addr, reglk_i);
            run_txn(we, addr, wd, $urandom_range(0, 2), $urandom_range(0, 2),
                    ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), e,
                    $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
